// File: rtl/rr_arbiter41_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter41_if -- request/data/grant bundle for the 4:1 round-robin arbiter.
//
// Signals (named from the arbiter's point of view):
//   iReq[3:0]        request bit per requester
//   iC0..iC3[DW-1:0] data word offered by requesters 0..3
//   oGnt[3:0]        one-hot grant, 0 when idle
//   oS1, oS0         binary owner index (datapath select code)
//   oZ[DW-1:0]       registered data word of the granted requester
//   oValid           oZ holds owner data
//
// Modports: master = requester side / testbench, slave = arbiter.
// ---------------------------------------------------------------------------
interface rr_arbiter41_if #(
  parameter int DW = 4
);
  logic [3:0]    iReq;
  logic [DW-1:0] iC0;
  logic [DW-1:0] iC1;
  logic [DW-1:0] iC2;
  logic [DW-1:0] iC3;
  logic [3:0]    oGnt;
  logic          oS1;
  logic          oS0;
  logic [DW-1:0] oZ;
  logic          oValid;

  modport master (
    output iReq, iC0, iC1, iC2, iC3,
    input  oGnt, oS1, oS0, oZ, oValid
  );

  modport slave (
    input  iReq, iC0, iC1, iC2, iC3,
    output oGnt, oS1, oS0, oZ, oValid
  );
endinterface

// File: rtl/rr_arbiter41.sv
// ---------------------------------------------------------------------------
// rr_arbiter41 -- 4-requester round-robin arbiter driving a shared 4:1
// datapath. A grant is held for as long as its owner keeps requesting; when
// the owner releases, the next pending requester after it takes over at the
// same edge. The granted requester's word is registered onto oZ one cycle
// behind the grant.
//
// Ports:
//   iClk  clock, all state updates on the rising edge
//   iRst  synchronous, active-high reset (pointer set so requester 0 wins first)
//   bus   rr_arbiter41_if.slave: iReq, iC0..iC3, oGnt, oS1, oS0, oZ, oValid
//
// Optional feature (macro ARB_TIMEOUT_EN): a 3-bit hold counter forces a
// round-robin handover after 8 consecutive cycles of one owner, but only when
// some other requester is waiting.
// ---------------------------------------------------------------------------
module rr_arbiter41 #(
  parameter int DW = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  rr_arbiter41_if.slave       bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbState_t;

  arbState_t     state;
  logic [1:0]    owner;
  logic [1:0]    ptr;

  logic [3:0]    others;
  logic [1:0]    winner;
  logic          doGrant;
  logic          doHold;
  logic          timeoutHit;
  logic [DW-1:0] ownerData;

`ifdef ARB_TIMEOUT_EN
  logic [2:0]    holdCnt;
`endif

  // First set bit searched from base+1 upward, wrapping to base itself last.
  // Looping from the farthest offset down lets the nearest hit win.
  function automatic logic [1:0] rrPick(input logic [1:0] base, input logic [3:0] req);
    logic [1:0] idx;
    rrPick = base;
    for (int k = 3; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) rrPick = idx;
    end
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    others     = bus.iReq & ~(4'b0001 << owner);
    timeoutHit = 1'b0;
`ifdef ARB_TIMEOUT_EN
    timeoutHit = (holdCnt == 3'd7) && (others != 4'b0000);
`endif
    winner  = (state == IDLE) ? rrPick(ptr, bus.iReq) : rrPick(owner, others);
    doHold  = (state == BUSY) && bus.iReq[owner] && !timeoutHit;
    doGrant = (state == IDLE) ? (bus.iReq != 4'b0000)
                              : (!doHold && (others != 4'b0000));

    unique case (owner)
      2'd0:    ownerData = bus.iC0;
      2'd1:    ownerData = bus.iC1;
      2'd2:    ownerData = bus.iC2;
      default: ownerData = bus.iC3;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      owner      <= 2'd0;
      ptr        <= 2'd3;
      bus.oGnt   <= 4'b0000;
      bus.oS1    <= 1'b0;
      bus.oS0    <= 1'b0;
      bus.oZ     <= '0;
      bus.oValid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      holdCnt    <= 3'd0;
`endif
    end else begin
      // The datapath register follows the grant as it stood before this edge.
      if (state == BUSY) begin
        bus.oZ     <= ownerData;
        bus.oValid <= 1'b1;
      end else begin
        bus.oZ     <= '0;
        bus.oValid <= 1'b0;
      end

      if (doGrant) begin
        state              <= BUSY;
        owner              <= winner;
        ptr                <= winner;
        bus.oGnt           <= 4'b0001 << winner;
        {bus.oS1, bus.oS0} <= winner;
`ifdef ARB_TIMEOUT_EN
        holdCnt            <= 3'd0;
`endif
      end else if (doHold) begin
`ifdef ARB_TIMEOUT_EN
        // Saturates when the owner is alone, so it keeps the grant.
        if (holdCnt != 3'd7) holdCnt <= holdCnt + 3'd1;
`endif
      end else begin
        // No requests: drop to idle; ptr keeps the last owner.
        state              <= IDLE;
        bus.oGnt           <= 4'b0000;
        {bus.oS1, bus.oS0} <= 2'b00;
      end
    end
  end

endmodule
